load_hazard_stall_ctrl: RTL
===========================

// Module: load_hazard_stall_ctrl
// PURPOSE
//  Parametrised load-use hazard controller for the 5-stage pipeline, sitting beside ID/EX.
//  Detects a load in EX whose rd feeds an ID-stage source.
//  Holds PC and IF/ID and injects EX bubbles for LOAD_LAT cycles (multi-cycle data memory).
//  Honours global pipeline freeze (MemStall_i).
//  Filters unused source operands and keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_ADDR_W   5   register index width
//  LOAD_LAT     1   stall cycles per load-use hazard (>=1; 1 = classic single bubble)
//  LAT_W        4   width of latency down-counter (2**LAT_W > LOAD_LAT)
//  CNT_W        32  width of StallCycles_o performance counter
//  ZERO_REG     1   1: register 0 is hardwired, rd==0 never causes a hazard
// PORTS
//  clk_i            in   1           clock, all state updates on rising edge
//  rst_i            in   1           reset, synchronous, active-low
//  MemStall_i       in   1           global pipeline freeze (D-cache miss); all latches hold
//  MemReadSignal_i  in   1           ID/EX MemRead (EX instruction is a load)
//  RD_i             in   REG_ADDR_W  ID/EX destination register
//  RS1_i            in   REG_ADDR_W  IF/ID source 1
//  RS2_i            in   REG_ADDR_W  IF/ID source 2
//  RS1Used_i        in   1           ID instruction reads RS1
//  RS2Used_i        in   1           ID instruction reads RS2
//  noOpSignal_o     out  1           force ID/EX control to bubble
//  stallSignal_o    out  1           hold IF/ID latch
//  PCWriteSignal_o  out  1           PC write enable (0 = hold)
//  StallCycles_o    out  CNT_W       count of effective hazard-stall cycles
// BEHAVIOUR
//  hit = MemReadSignal_i & (RD_i!=0 | ZERO_REG==0) & ((RS1Used_i & RS1_i==RD_i) | (RS2Used_i & RS2_i==RD_i)).
//  State: IDLE / STALL; cnt[LAT_W-1:0].
//  Reset (rst_i==0 at edge): state<=IDLE, cnt<=0, StallCycles_o<=0.
//  While rst_i==0, outputs are forced to noOp=0, stall=0, PCWrite=1.
//  IDLE outputs are combinational, same cycle as detection: noOp=hit, stall=hit, PCWrite=~hit.
//  IDLE->STALL at edge when hit & ~MemStall_i & LOAD_LAT>1; cnt<=LOAD_LAT-1.
//    - With LOAD_LAT==1, remain IDLE; the next cycle sees a bubble in EX, so there is no re-trigger.
//    - With hit & MemStall_i, remain IDLE (frozen) and re-evaluate next cycle.
//  STALL outputs: noOp=1, stall=1, PCWrite=0 unconditionally; hazard inputs are ignored.
//  STALL with ~MemStall_i: cnt<=cnt-1; cnt==1 -> IDLE at that edge.
//  STALL with MemStall_i: cnt and state hold.
//  Total asserted cycles per hazard = LOAD_LAT plus any frozen cycles.
//  StallCycles_o += 1 on each edge where stallSignal_o==1 & MemStall_i==0 & rst_i==1.
//    - Saturates at all-ones; never wraps.
//  No X on outputs after the first reset edge; illegal LOAD_LAT==0 is treated as 1.
// TESTING
//  1 LOAD_LAT=1: MemRead=1,RD=5,RS1=5,RS1Used=1 for 1 cycle, then bubble
//    -> exactly 1 cycle noOp=1,stall=1,PCWrite=0; StallCycles_o=1.
//  2 RD=0,RS1=0,MemRead=1 -> no stall.
//    RS2=7,RD=7,RS2Used=0,RS1 mismatch -> no stall; set RS2Used=1 -> stall asserted same cycle.
//  3 LOAD_LAT=3: hit for 1 cycle, then bubble inputs
//    -> outputs asserted exactly 3 consecutive cycles, back to IDLE, StallCycles_o=3.
//  4 LOAD_LAT=3: MemStall_i=1 for 2 cycles during STALL
//    -> stall asserted 5 cycles total, StallCycles_o=3.
//  5 LOAD_LAT=4: rst_i=0 for 1 cycle mid-STALL
//    -> outputs cleared during reset, IDLE after edge, StallCycles_o=0.
//  6 CNT_W=4: 20 back-to-back single-cycle hazards -> StallCycles_o saturates at 15.

Source files
------------

// File: rtl/load_hazard_stall_ctrl.sv
// Load-use hazard controller beside ID/EX: detects a load in EX feeding an ID source,
// holds PC and IF/ID and bubbles EX for LOAD_LAT cycles, honouring a global freeze.
module load_hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int LAT_W      = 4,
    parameter int CNT_W      = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  MemStall_i,
    input  logic                  MemReadSignal_i,
    input  logic [REG_ADDR_W-1:0] RD_i,
    input  logic [REG_ADDR_W-1:0] RS1_i,
    input  logic [REG_ADDR_W-1:0] RS2_i,
    input  logic                  RS1Used_i,
    input  logic                  RS2Used_i,
    output logic                  noOpSignal_o,
    output logic                  stallSignal_o,
    output logic                  PCWriteSignal_o,
    output logic [CNT_W-1:0]      StallCycles_o
);

    // A zero latency makes no sense for a load; fall back to the classic single bubble.
    localparam int LAT_EFF = (LOAD_LAT < 1) ? 1 : LOAD_LAT;
    localparam bit MULTI_CYCLE = (LAT_EFF > 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LAT_EFF - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic rd_valid;
    logic rs1_hit;
    logic rs2_hit;
    logic hit;
    logic hold_pipe;

    always_comb begin
        rd_valid = (RD_i != '0) || (ZERO_REG == 0);
        rs1_hit  = RS1Used_i && (RS1_i == RD_i);
        rs2_hit  = RS2Used_i && (RS2_i == RD_i);
        hit      = MemReadSignal_i && rd_valid && (rs1_hit || rs2_hit);
    end

    // In STALL the hazard inputs are ignored; in IDLE detection drives outputs the same cycle.
    always_comb begin
        hold_pipe = 1'b0;
        if (rst_i) begin
            hold_pipe = (state_q == STALL) || hit;
        end
        noOpSignal_o    = hold_pipe;
        stallSignal_o   = hold_pipe;
        PCWriteSignal_o = ~hold_pipe;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!MemStall_i) begin
            case (state_q)
                IDLE: begin
                    if (hit && MULTI_CYCLE) begin
                        state_d = STALL;
                        cnt_d   = LAT_INIT;
                    end
                end
                STALL: begin
                    if (cnt_q == LAT_ONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - LAT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Performance counter saturates rather than wrapping so long runs stay meaningful.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stallSignal_o && !MemStall_i && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign StallCycles_o = stall_cycles_q;

endmodule
